// File: rtl/sensor_link_pkg.sv
// Definitions shared by both ends of the sensor request/response link:
// checksum key, frame geometry, state encodings and the checksum helper.
package sensor_link_pkg;

    localparam logic [7:0] CHECK_KEY_DEF = 8'h37;
    localparam int         FRAME_BITS    = 10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_SEND_DATA = 2'd2,
        ST_SEND_SUM  = 2'd3
    } link_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [7:0] frame_checksum(input logic [7:0] data, input logic [7:0] key);
        return data ^ key;
    endfunction

endpackage

// File: rtl/sensor_responder_if.sv
// Serial pins, sensor fetch port and status pulses of the sensor responder.
// master = the responder itself, slave = the board around it.
interface sensor_responder_if;
    logic       rx;
    logic       tx;
    logic       sens_req;
    logic [7:0] sens_addr;
    logic       sens_ack;
    logic [7:0] sens_data;
    logic       busy;
    logic       frame_err;
    logic       drop;
    logic       timeout_err;

    modport master (
        input  rx, sens_ack, sens_data,
        output tx, sens_req, sens_addr, busy, frame_err, drop, timeout_err
    );

    modport slave (
        output rx, sens_ack, sens_data,
        input  tx, sens_req, sens_addr, busy, frame_err, drop, timeout_err
    );
endinterface

// File: rtl/resp_serializer.sv
// 8N1 transmitter for one response byte. A start accepted in the same cycle
// as done chains the next frame with no idle gap on the line.
module resp_serializer
    import sensor_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       done_o
);
    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

    logic                  active_q, active_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  done_s;

    assign done_s = active_q && (bit_q == BIT_LAST) && (cnt_q == CNT_LAST);
    assign done_o = done_s;
    assign tx_o   = tx_q;

    // Bit timing and shift-out of the current frame
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (start_i && (!active_q || done_s)) begin
            active_d = 1'b1;
            cnt_d    = {CW{1'b0}};
            bit_d    = 4'd0;
            shift_d  = {1'b1, byte_i, 1'b0};
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CW{1'b0}};
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    tx_d    = shift_q[1];
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            tx_d = 1'b1;
        end
    end

    // Serializer state registers; the line idles high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            bit_q    <= 4'd0;
            shift_q  <= {FRAME_BITS{1'b1}};
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/sensor_responder.sv
// Sensor-side end of the serial link: decodes a request byte, fetches the
// sensor value and answers with the data byte followed by its checksum.
module sensor_responder
    import sensor_link_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         NUM_SENSORS  = 32,
    parameter logic [7:0] CHECK_KEY    = CHECK_KEY_DEF,
    parameter int         ACK_TIMEOUT  = 1024
)(
    input logic              clock,
    input logic              reset,
    sensor_responder_if.master link
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam int            AW        = $clog2(ACK_TIMEOUT);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [AW-1:0] ACK_ONE   = {{(AW-1){1'b0}}, 1'b1};

    // Receive path
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_done_s, rx_ferr_s, rx_index_ok_s;

    // Main FSM and registered outputs
    link_state_e   state_q, state_d;
    logic          sens_req_q, sens_req_d;
    logic [7:0]    sens_addr_q, sens_addr_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic          frame_err_q;
    logic          timeout_err_q, timeout_err_d;

    logic          ser_start_s, ser_done_s, ser_tx_s;
    logic [7:0]    ser_byte_s;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= link.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Deserializer: half-bit start check, then one sample per bit period
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_s  = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = {CW{1'b0}};
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = {CW{1'b0}};
                    rx_bit_d = 3'd0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = {CW{1'b0}};
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = {CW{1'b0}};
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_done_s = 1'b1;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Deserializer state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= {CW{1'b0}};
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    assign rx_index_ok_s = ({24'd0, rx_shift_q} < 32'(NUM_SENSORS));

    // Main FSM: accept request, fetch with timeout, then send data and checksum
    always_comb begin
        state_d       = state_q;
        sens_req_d    = sens_req_q;
        sens_addr_d   = sens_addr_q;
        sum_d         = sum_q;
        ack_cnt_d     = ack_cnt_q;
        drop_d        = 1'b0;
        timeout_err_d = 1'b0;
        ser_start_s   = 1'b0;
        ser_byte_s    = sum_q;
        case (state_q)
            ST_IDLE: begin
                ack_cnt_d = {AW{1'b0}};
                if (rx_done_s) begin
                    if (rx_index_ok_s) begin
                        sens_addr_d = rx_shift_q;
                        sens_req_d  = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                drop_d = rx_done_s;
                // An ack in the expiry cycle still wins over the timeout
                if (link.sens_ack) begin
                    sum_d       = frame_checksum(link.sens_data, CHECK_KEY);
                    sens_req_d  = 1'b0;
                    ser_start_s = 1'b1;
                    ser_byte_s  = link.sens_data;
                    state_d     = ST_SEND_DATA;
                end else if (ack_cnt_q == ACK_LAST) begin
                    sens_req_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_ONE;
                end
            end
            ST_SEND_DATA: begin
                drop_d = rx_done_s;
                if (ser_done_s) begin
                    ser_start_s = 1'b1;
                    ser_byte_s  = sum_q;
                    state_d     = ST_SEND_SUM;
                end else begin
                    state_d = ST_SEND_DATA;
                end
            end
            ST_SEND_SUM: begin
                drop_d = rx_done_s;
                if (ser_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND_SUM;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                sens_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Main FSM state and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sens_req_q    <= 1'b0;
            sens_addr_q   <= 8'h00;
            sum_q         <= 8'h00;
            ack_cnt_q     <= {AW{1'b0}};
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sens_req_q    <= sens_req_d;
            sens_addr_q   <= sens_addr_d;
            sum_q         <= sum_d;
            ack_cnt_q     <= ack_cnt_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
            frame_err_q   <= rx_ferr_s;
            timeout_err_q <= timeout_err_d;
        end
    end

    resp_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clock   (clock),
        .reset   (reset),
        .start_i (ser_start_s),
        .byte_i  (ser_byte_s),
        .tx_o    (ser_tx_s),
        .done_o  (ser_done_s)
    );

    assign link.tx          = ser_tx_s;
    assign link.sens_req    = sens_req_q;
    assign link.sens_addr   = sens_addr_q;
    assign link.busy        = busy_q;
    assign link.drop        = drop_q;
    assign link.frame_err   = frame_err_q;
    assign link.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sensor_responder.sv
// Randomized bench for sensor_responder: drives request bytes on rx, plays the
// sensor, decodes tx frames and compares them with a queue-based response model.
module tb_sensor_responder;
    localparam int         CPB   = 8;
    localparam int         NSENS = 32;
    localparam int         ATO   = 64;
    localparam logic [7:0] KEY   = 8'h37;

    logic clock = 1'b0;
    logic reset = 1'b0;

    sensor_responder_if link();

    sensor_responder #(
        .CLKS_PER_BIT (CPB),
        .NUM_SENSORS  (NSENS),
        .CHECK_KEY    (KEY),
        .ACK_TIMEOUT  (ATO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .link  (link)
    );

    always #5 clock = ~clock;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int drop_cnt = 0;
    int ferr_cnt = 0;
    int tout_cnt = 0;

    logic [9:0] mon_q[$];
    int         mon_t[$];
    logic [7:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            if (link.drop)        drop_cnt++;
            if (link.frame_err)   ferr_cnt++;
            if (link.timeout_err) tout_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Decodes every frame on tx at mid-bit; a reset mid-frame discards it
    initial begin : tx_monitor
        forever begin
            @(negedge clock);
            if (reset && (link.tx == 1'b0)) begin : frame
                int         t0;
                logic [9:0] bits;
                bit         aborted;
                t0 = cyc;
                bits = 10'h000;
                aborted = 1'b0;
                for (int off = 0; off <= 9 * CPB + CPB / 2; off++) begin
                    if (off != 0) @(negedge clock);
                    if (!reset) aborted = 1'b1;
                    if (!aborted && ((off % CPB) == CPB / 2)) bits[off / CPB] = link.tx;
                end
                if (!aborted) begin
                    mon_q.push_back(bits);
                    mon_t.push_back(t0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        link.rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            link.rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        link.rx = stop_bit;
        repeat (CPB) @(negedge clock);
        link.rx = 1'b1;
    endtask

    // One request transaction; intr_b >= 0 sends a second byte mid-response,
    // rst_off > 0 pulses reset that many cycles after the ack
    task automatic run_req(input logic [7:0] b, input logic [7:0] d, input int dly,
                           input bit ack_it, input int intr_b, input int rst_off);
        int  c0, c1, r, a, drops0, touts0;
        bit  valid;
        logic [7:0] ib;
        valid  = (int'(b) < NSENS);
        drops0 = drop_cnt;
        touts0 = tout_cnt;
        ib     = intr_b[7:0];
        mon_q.delete();
        mon_t.delete();
        exp_q.delete();
        c0 = cyc;
        fork
            send_byte(b, 1'b1);
        join_none
        wait_until(c0 + 78);
        check_eq("req_before_stop", link.sens_req, 1'b0);
        @(negedge clock);
        r = cyc;
        check_eq("req_after_stop", link.sens_req, valid);
        check_eq("drop_after_stop", link.drop, !valid);
        if (!valid) begin
            wait_until(r + 4 * CPB);
            check_eq("invalid_no_req", link.sens_req, 1'b0);
            check_eq("invalid_not_busy", link.busy, 1'b0);
            check_eq("invalid_tx_silent", mon_q.size(), 0);
            check_eq("invalid_drop_once", drop_cnt - drops0, 1);
            return;
        end
        check_eq("sens_addr", link.sens_addr, b);
        check_eq("busy_fetch", link.busy, 1'b1);
        if (!ack_it) begin
            wait_until(r + ATO - 1);
            check_eq("tout_not_yet", link.timeout_err, 1'b0);
            check_eq("req_held", link.sens_req, 1'b1);
            @(negedge clock);
            check_eq("tout_pulse", link.timeout_err, 1'b1);
            @(negedge clock);
            check_eq("tout_busy_low", link.busy, 1'b0);
            check_eq("tout_req_low", link.sens_req, 1'b0);
            check_eq("tout_one_cycle", link.timeout_err, 1'b0);
            wait_until(r + ATO + 20 * CPB);
            check_eq("tout_tx_silent", mon_q.size(), 0);
            return;
        end
        wait_until(r + dly);
        a = cyc;
        link.sens_ack  = 1'b1;
        link.sens_data = d;
        exp_q.push_back(d);
        exp_q.push_back(d ^ KEY);
        @(negedge clock);
        link.sens_ack  = 1'b0;
        link.sens_data = 8'($urandom);
        check_eq("req_low_after_ack", link.sens_req, 1'b0);
        check_eq("tx_start_after_ack", link.tx, 1'b0);
        if (rst_off > 0) begin
            wait_until(a + rst_off);
            reset = 1'b0;
            #1;
            check_eq("rst_tx", link.tx, 1'b1);
            check_eq("rst_busy", link.busy, 1'b0);
            check_eq("rst_req", link.sens_req, 1'b0);
            check_eq("rst_addr", link.sens_addr, 8'h00);
            repeat (3) @(negedge clock);
            reset = 1'b1;
            repeat (2) @(negedge clock);
            exp_q.delete();
            mon_q.delete();
            mon_t.delete();
            return;
        end
        if (intr_b >= 0) begin
            wait_until(a + 10);
            c1 = cyc;
            fork
                send_byte(ib, 1'b1);
            join_none
            wait_until(c1 + 79);
            check_eq("busy_drop_pulse", link.drop, 1'b1);
            check_eq("busy_drop_no_req", link.sens_req, 1'b0);
        end
        wait_until(a + 20 * CPB);
        check_eq("busy_last_stop", link.busy, 1'b1);
        @(negedge clock);
        check_eq("busy_after_resp", link.busy, 1'b0);
        wait_until(a + 20 * CPB + 4);
        check_eq("resp_frame_count", mon_q.size(), 2);
        for (int k = 0; k < 2; k++) begin
            if ((mon_q.size() > 0) && (exp_q.size() > 0)) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check_eq("resp_frame", mon_q.pop_front(), {1'b1, e, 1'b0});
                check_eq("resp_start_cycle", mon_t.pop_front(), a + 1 + k * 10 * CPB);
            end
        end
        check_eq("resp_drop_count", drop_cnt - drops0, (intr_b >= 0) ? 1 : 0);
        check_eq("resp_no_timeout", tout_cnt - touts0, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int f0, d0;
        link.rx        = 1'b1;
        link.sens_ack  = 1'b0;
        link.sens_data = 8'h00;
        repeat (3) @(negedge clock);
        check_eq("reset_tx", link.tx, 1'b1);
        check_eq("reset_busy", link.busy, 1'b0);
        check_eq("reset_req", link.sens_req, 1'b0);
        check_eq("reset_addr", link.sens_addr, 8'h00);
        check_eq("reset_drop", link.drop, 1'b0);
        check_eq("reset_ferr", link.frame_err, 1'b0);
        check_eq("reset_tout", link.timeout_err, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        run_req(8'h05, 8'h5A, 2, 1'b1, -1, 0);
        repeat (5) @(negedge clock);
        run_req(8'h40, 8'h00, 0, 1'b1, -1, 0);
        repeat (5) @(negedge clock);
        run_req(8'h20, 8'h00, 0, 1'b1, -1, 0);
        repeat (5) @(negedge clock);
        run_req(8'h1F, 8'h81, ATO - 1, 1'b1, -1, 0);
        repeat (5) @(negedge clock);
        run_req(8'h03, 8'h00, 0, 1'b0, -1, 0);
        repeat (5) @(negedge clock);
        run_req(8'h04, 8'hA5, 1, 1'b1, -1, 0);
        repeat (5) @(negedge clock);
        run_req(8'h01, 8'h3C, 3, 1'b1, 8'h07, 0);
        repeat (5) @(negedge clock);

        begin : frame_error_and_glitch
            int c0;
            f0 = ferr_cnt;
            d0 = drop_cnt;
            c0 = cyc;
            fork
                send_byte(8'h03, 1'b0);
            join_none
            wait_until(c0 + 79);
            check_eq("ferr_pulse", link.frame_err, 1'b1);
            check_eq("ferr_no_req", link.sens_req, 1'b0);
            @(negedge clock);
            check_eq("ferr_one_cycle", link.frame_err, 1'b0);
            wait_until(c0 + 100);
            check_eq("ferr_count", ferr_cnt - f0, 1);
            f0 = ferr_cnt;
            link.rx = 1'b0;
            repeat (2) @(negedge clock);
            link.rx = 1'b1;
            repeat (12 * CPB) @(negedge clock);
            check_eq("glitch_no_ferr", ferr_cnt - f0, 0);
            check_eq("glitch_no_drop", drop_cnt - d0, 0);
            check_eq("glitch_not_busy", link.busy, 1'b0);
            check_eq("glitch_no_req", link.sens_req, 1'b0);
        end

        run_req(8'h05, 8'h5A, 2, 1'b1, -1, 1 + 5 * CPB);
        repeat (5) @(negedge clock);
        run_req(8'h00, 8'hFF, 2, 1'b1, -1, 0);
        repeat (5) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] rb, rd;
            int         rdly;
            rb   = 8'($urandom_range(0, 47));
            rd   = 8'($urandom_range(0, 255));
            rdly = $urandom_range(0, 6);
            run_req(rb, rd, rdly, 1'b1, -1, 0);
            repeat (5) @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
